// File: rtl/barrel_shifter_4bit_pkg.sv
// Shared constants for the registered 4-bit barrel shifter.
// Widths plus direction and mode encodings.
package barrel_shifter_4bit_pkg;
   localparam int WIDTH = 4;
   localparam int SHW   = 2;

   localparam logic DIR_RIGHT  = 1'b0;
   localparam logic DIR_LEFT   = 1'b1;
   localparam logic MODE_SHIFT = 1'b0;
   localparam logic MODE_ROT   = 1'b1;

   typedef logic [WIDTH-1:0] data_t;
   typedef logic [SHW-1:0]   amt_t;
endpackage

// File: rtl/barrel_shifter_4bit_if.sv
// Operand/result bundle between a producer and the shifter.
// The producer drives the master side, the shifter is the slave.
interface barrel_shifter_4bit_if;
   import barrel_shifter_4bit_pkg::*;

   logic  in_valid;
   data_t d;
   amt_t  s;
   logic  dir;
   logic  rot;
   data_t y;
   logic  out_valid;

   modport master (
      output in_valid, d, s, dir, rot,
      input  y, out_valid
   );

   modport slave (
      input  in_valid, d, s, dir, rot,
      output y, out_valid
   );
endinterface

// File: rtl/barrel_shifter_4bit_mux2.sv
// One-bit 2:1 mux, the building cell of each shift stage.
// sel=0 passes a, sel=1 takes the neighbour on b.
module mux2 (
   input  logic a,
   input  logic b,
   input  logic sel,
   output logic y
);
   assign y = sel ? b : a;
endmodule

// File: rtl/barrel_shifter_4bit.sv
// Registered nibble shifter/rotator: two log stages per direction,
// a final direction select, then the result and valid flops.
module barrel_shifter_4bit
   import barrel_shifter_4bit_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   barrel_shifter_4bit_if.slave bs
);
   logic  w_wrap;
   data_t w_r1b, w_r1, w_r2b, w_r2;
   data_t w_l1b, w_l1, w_l2b, w_l2;
   data_t w_res;
   data_t r_y;
   logic  r_vld;

   assign w_wrap = (bs.rot == MODE_ROT);

   // Out-of-range neighbours are gated to zero unless rotating.
   for (genvar i = 0; i < WIDTH; i++) begin : g_st1
      localparam int RI = (i + 1) % WIDTH;
      localparam int LI = (i + WIDTH - 1) % WIDTH;

      assign w_r1b[i] = (i + 1 < WIDTH) ? bs.d[RI]
                                        : (w_wrap & bs.d[RI]);
      assign w_l1b[i] = (i >= 1) ? bs.d[LI]
                                 : (w_wrap & bs.d[LI]);

      mux2 u_r (
         .a   (bs.d[i]),
         .b   (w_r1b[i]),
         .sel (bs.s[0]),
         .y   (w_r1[i])
      );
      mux2 u_l (
         .a   (bs.d[i]),
         .b   (w_l1b[i]),
         .sel (bs.s[0]),
         .y   (w_l1[i])
      );
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_st2
      localparam int RI = (i + 2) % WIDTH;
      localparam int LI = (i + WIDTH - 2) % WIDTH;

      assign w_r2b[i] = (i + 2 < WIDTH) ? w_r1[RI]
                                        : (w_wrap & w_r1[RI]);
      assign w_l2b[i] = (i >= 2) ? w_l1[LI]
                                 : (w_wrap & w_l1[LI]);

      mux2 u_r (
         .a   (w_r1[i]),
         .b   (w_r2b[i]),
         .sel (bs.s[1]),
         .y   (w_r2[i])
      );
      mux2 u_l (
         .a   (w_l1[i]),
         .b   (w_l2b[i]),
         .sel (bs.s[1]),
         .y   (w_l2[i])
      );
   end

   assign w_res = (bs.dir == DIR_LEFT) ? w_l2 : w_r2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_y   <= '0;
         r_vld <= 1'b0;
      end else begin
         r_vld <= bs.in_valid;
         if (bs.in_valid) begin
            r_y <= w_res;
         end
      end
   end

   assign bs.y         = r_y;
   assign bs.out_valid = r_vld;
endmodule

// File: tb/tb_barrel_shifter_4bit.sv
// Directed table plus exhaustive sweep against an index-formula model,
// with hand-written reset, valid-gating and async-reset sequences.
module tb_barrel_shifter_4bit;
   import barrel_shifter_4bit_pkg::*;

   typedef struct {
      logic [3:0] d;
      logic [1:0] s;
      logic       dir;
      logic       rot;
      logic [3:0] exp;
   } vec_t;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;
   vec_t vecs [17];

   barrel_shifter_4bit_if u_if ();

   barrel_shifter_4bit u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bs    (u_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name,
                        input logic [3:0] act,
                        input logic [3:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   function automatic logic [3:0] model(input logic [3:0] d,
                                        input int n,
                                        input logic dir,
                                        input logic rot);
      logic [3:0] r;
      int idx;
      for (int i = 0; i < 4; i++) begin
         idx = dir ? (i - n) : (i + n);
         if (idx >= 0 && idx <= 3)
            r[i] = d[idx];
         else
            r[i] = rot ? d[(idx + 4) % 4] : 1'b0;
      end
      return r;
   endfunction

   function automatic vec_t mk(input logic [3:0] d,
                               input logic [1:0] s,
                               input logic dir,
                               input logic rot,
                               input logic [3:0] exp);
      vec_t v;
      v.d = d; v.s = s; v.dir = dir; v.rot = rot; v.exp = exp;
      return v;
   endfunction

   task automatic drive(input logic v, input logic [3:0] d,
                        input logic [1:0] s, input logic dir,
                        input logic rot);
      u_if.in_valid = v;
      u_if.d        = d;
      u_if.s        = s;
      u_if.dir      = dir;
      u_if.rot      = rot;
   endtask

   initial begin
      logic [7:0] k;
      logic [3:0] e;
      n_checks = 0;
      n_errors = 0;

      vecs[0]  = mk(4'b1101, 2'd0, 1'b0, 1'b1, 4'b1101);
      vecs[1]  = mk(4'b1101, 2'd1, 1'b0, 1'b1, 4'b1110);
      vecs[2]  = mk(4'b1101, 2'd2, 1'b0, 1'b1, 4'b0111);
      vecs[3]  = mk(4'b1101, 2'd3, 1'b0, 1'b1, 4'b1011);
      vecs[4]  = mk(4'b0011, 2'd1, 1'b0, 1'b1, 4'b1001);
      vecs[5]  = mk(4'b1010, 2'd2, 1'b0, 1'b1, 4'b1010);
      vecs[6]  = mk(4'b1101, 2'd1, 1'b1, 1'b1, 4'b1011);
      vecs[7]  = mk(4'b1101, 2'd2, 1'b1, 1'b1, 4'b0111);
      vecs[8]  = mk(4'b1101, 2'd3, 1'b1, 1'b1, 4'b1110);
      vecs[9]  = mk(4'b1101, 2'd1, 1'b0, 1'b0, 4'b0110);
      vecs[10] = mk(4'b1101, 2'd3, 1'b0, 1'b0, 4'b0001);
      vecs[11] = mk(4'b1101, 2'd1, 1'b1, 1'b0, 4'b1010);
      vecs[12] = mk(4'b1101, 2'd3, 1'b1, 1'b0, 4'b1000);
      vecs[13] = mk(4'b1101, 2'd0, 1'b0, 1'b0, 4'b1101);
      vecs[14] = mk(4'b1101, 2'd0, 1'b1, 1'b0, 4'b1101);
      vecs[15] = mk(4'b1101, 2'd0, 1'b1, 1'b1, 4'b1101);
      vecs[16] = mk(4'b1101, 2'd2, 1'b0, 1'b0, 4'b0011);

      // Reset held with random valid inputs
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 4'($urandom), 2'($urandom),
               1'($urandom), 1'($urandom));
         @(posedge clk);
         #1;
         check("rst_y", u_if.y, 4'b0000);
         check("rst_vld", {3'b0, u_if.out_valid}, 4'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      // Directed table, back-to-back valid inputs
      foreach (vecs[i]) begin
         @(negedge clk);
         drive(1'b1, vecs[i].d, vecs[i].s,
               vecs[i].dir, vecs[i].rot);
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_y", i), u_if.y, vecs[i].exp);
         check($sformatf("vec%0d_vld", i),
               {3'b0, u_if.out_valid}, 4'd1);
      end

      // Valid gating: y holds, out_valid drops
      @(negedge clk);
      drive(1'b1, 4'b0011, 2'd1, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      check("gate_pre_y", u_if.y, 4'b1001);
      @(negedge clk);
      drive(1'b0, 4'b1111, 2'd2, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      check("gate_hold_y", u_if.y, 4'b1001);
      check("gate_vld", {3'b0, u_if.out_valid}, 4'd0);

      // Async reset between edges
      @(negedge clk);
      drive(1'b1, 4'b1101, 2'd3, 1'b1, 1'b1);
      @(posedge clk);
      #1;
      check("arst_pre_y", u_if.y, 4'b1110);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_y", u_if.y, 4'b0000);
      check("arst_vld", {3'b0, u_if.out_valid}, 4'd0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 4'b1010, 2'd1, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      check("arst_rec_y", u_if.y, 4'b0100);
      check("arst_rec_vld", {3'b0, u_if.out_valid}, 4'd1);

      // Exhaustive sweep
      for (int n = 0; n < 256; n++) begin
         k = 8'(n);
         e = model(k[3:0], int'(k[5:4]), k[6], k[7]);
         @(negedge clk);
         drive(1'b1, k[3:0], k[5:4], k[6], k[7]);
         @(posedge clk);
         #1;
         check($sformatf("exh%0d", n), u_if.y, e);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end
endmodule
